rtc_bus_arbiter: RTL and testbench

- Shares the single RTC register-access bus (address/data/write strobe to the RTC protocol engine) among three requesters.
  - Requester 0: countdown-timer machine.
  - Requester 1: time/date programming machine.
  - Requester 2: periodic readback refresh.
- Round-robin arbitration; one transaction at a time.
- Runs a start/done handshake with the protocol engine and enforces a recovery gap between transactions.
- Replaces the ad-hoc tristated address/data driving with one owned, registered bus.

---
 rtl/rtc_bus_pkg.sv | 24 ++
 rtl/rr_pick3.sv | 35 +++
 rtl/rtc_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// RTC bus arbiter shared types and constants.
// FSM encoding, requester indices and counter sizing helper.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

    localparam int REQ_CRONO = 0;
    localparam int REQ_PROG  = 1;
    localparam int REQ_READ  = 2;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin selector.
// Picks the first requester at or after ptr; one-hot result.
module rr_pick3
    import rtc_bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] sel,
    output logic       valid
);

    always_comb begin
        sel = '0;
        case (ptr)
            2'd1: begin
                if (req[REQ_PROG])       sel[REQ_PROG]  = 1'b1;
                else if (req[REQ_READ])  sel[REQ_READ]  = 1'b1;
                else if (req[REQ_CRONO]) sel[REQ_CRONO] = 1'b1;
            end
            2'd2: begin
                if (req[REQ_READ])       sel[REQ_READ]  = 1'b1;
                else if (req[REQ_CRONO]) sel[REQ_CRONO] = 1'b1;
                else if (req[REQ_PROG])  sel[REQ_PROG]  = 1'b1;
            end
            default: begin
                if (req[REQ_CRONO])      sel[REQ_CRONO] = 1'b1;
                else if (req[REQ_PROG])  sel[REQ_PROG]  = 1'b1;
                else if (req[REQ_READ])  sel[REQ_READ]  = 1'b1;
            end
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the RTC register-access bus.
// One registered transaction at a time, with a recovery gap after each.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = 36,
    parameter int TIMEOUT    = 4095
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [2:0]          req,
    input  logic [2:0]          req_wr,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          done,
    output logic                err,
    output logic [DATA_W-1:0]   rd_data,
    output logic                bus_en,
    output logic                bus_start,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_data,
    input  logic                bus_done,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int WCW = cnt_w(TIMEOUT);
    localparam int GCW = cnt_w(GAP_CYCLES);

    arb_state_t        state, state_n;
    logic [2:0]        sel, sel_n, pick;
    logic              pick_v;
    logic [1:0]        ptr, ptr_n;
    logic [WCW-1:0]    wcnt, wcnt_n;
    logic [GCW-1:0]    gcnt, gcnt_n;
    logic              tflag, tflag_n;
    logic              wr_n, pick_wr;
    logic [ADDR_W-1:0] addr_n, pick_addr;
    logic [DATA_W-1:0] data_n, pick_wdata, rd_n;
    logic [2:0]        gnt_n, done_n;
    logic              err_n, en_n, start_n;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (ptr),
        .sel   (pick),
        .valid (pick_v)
    );

    always_comb begin
        pick_wr    = req_wr[REQ_CRONO];
        pick_addr  = req_addr[REQ_CRONO*ADDR_W +: ADDR_W];
        pick_wdata = req_wdata[REQ_CRONO*DATA_W +: DATA_W];
        unique case (1'b1)
            pick[REQ_PROG]: begin
                pick_wr    = req_wr[REQ_PROG];
                pick_addr  = req_addr[REQ_PROG*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[REQ_PROG*DATA_W +: DATA_W];
            end
            pick[REQ_READ]: begin
                pick_wr    = req_wr[REQ_READ];
                pick_addr  = req_addr[REQ_READ*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[REQ_READ*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        wcnt_n  = wcnt;
        gcnt_n  = gcnt;
        tflag_n = tflag;
        wr_n    = bus_wr;
        addr_n  = bus_addr;
        data_n  = bus_data;
        rd_n    = rd_data;
        case (state)
            ST_IDLE: if (pick_v) begin
                state_n = ST_START;
                sel_n   = pick;
                wr_n    = pick_wr;
                addr_n  = pick_addr;
                data_n  = pick_wr ? pick_wdata : '0;
                tflag_n = 1'b0;
            end
            ST_START: begin
                state_n = ST_WAIT;
                wcnt_n  = '0;
            end
            ST_WAIT: begin
                if (bus_done) begin
                    state_n = ST_DONE;
                    if (!bus_wr) rd_n = bus_rdata;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                    if (wcnt_n == WCW'(TIMEOUT)) begin
                        state_n = ST_DONE;
                        tflag_n = 1'b1;
                        rd_n    = '0;
                    end
                end
            end
            ST_DONE: begin
                gcnt_n  = '0;
                state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                unique case (1'b1)
                    sel[REQ_CRONO]: ptr_n = 2'd1;
                    sel[REQ_PROG]:  ptr_n = 2'd2;
                    default:        ptr_n = 2'd0;
                endcase
            end
            ST_GAP: begin
                gcnt_n = gcnt + 1'b1;
                if (gcnt_n == GCW'(GAP_CYCLES)) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        gnt_n   = (state_n inside {ST_START, ST_WAIT, ST_DONE}) ? sel_n : '0;
        done_n  = (state_n == ST_DONE) ? sel_n : '0;
        err_n   = (state_n == ST_DONE) && tflag_n;
        en_n    = (state_n inside {ST_START, ST_WAIT});
        start_n = (state_n == ST_START);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            sel       <= '0;
            ptr       <= '0;
            wcnt      <= '0;
            gcnt      <= '0;
            tflag     <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_data  <= '0;
            rd_data   <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            bus_en    <= 1'b0;
            bus_start <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            ptr       <= ptr_n;
            wcnt      <= wcnt_n;
            gcnt      <= gcnt_n;
            tflag     <= tflag_n;
            bus_wr    <= wr_n;
            bus_addr  <= addr_n;
            bus_data  <= data_n;
            rd_data   <= rd_n;
            gnt       <= gnt_n;
            done      <= done_n;
            err       <= err_n;
            bus_en    <= en_n;
            bus_start <= start_n;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter.
// Each task drives one scenario and checks against hand-computed values.
module tb_rtc_bus_arbiter;

    localparam int GAP = 36;

    logic            clk = 1'b0;
    logic            Reset;
    logic [2:0]      req, req_wr;
    logic [2:0][7:0] req_addr, req_wdata;
    logic [2:0]      gnt, done;
    logic            err, bus_en, bus_start, bus_wr, bus_done;
    logic [7:0]      rd_data, bus_addr, bus_data, bus_rdata;
    int              total = 0;
    int              bad = 0;

    rtc_bus_arbiter #(
        .ADDR_W(8), .DATA_W(8), .GAP_CYCLES(GAP), .TIMEOUT(4095)
    ) dut (
        .clk(clk), .Reset(Reset), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .bus_en(bus_en), .bus_start(bus_start), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_done(bus_done), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (bus_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic drain();
        repeat (GAP + 1) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) tick();
        total++;
        if ({gnt, done, err, bus_en, bus_start, bus_wr} !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {gnt, done, err, bus_en, bus_start, bus_wr});
        end
        total++;
        if ({bus_addr, bus_data, rd_data} !== 24'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0",
                     {bus_addr, bus_data, rd_data});
        end
        Reset = 1'b1;
    endtask

    task automatic test_contention();
        logic [2:0] order [4];
        bit ok;
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        Reset = 1'b0;
        req = 3'b111;
        req_wr = 3'b111;
        req_addr = {8'h12, 8'h11, 8'h10};
        req_wdata = {8'hA2, 8'hA1, 8'hA0};
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (i == 1) ? 1 : (i == 2) ? 2 : 0;
            wait_start(100, ok);
            total++;
            if (!ok || gnt !== order[i]) begin
                bad++;
                $display("FAIL contention_gnt%0d got=%b exp=%b", i, gnt, order[i]);
            end
            total++;
            if ({bus_wr, bus_addr, bus_data} !==
                {1'b1, 8'h10 + 8'(k), 8'hA0 + 8'(k)}) begin
                bad++;
                $display("FAIL contention_bus%0d got=%h exp=%h", i,
                         {bus_wr, bus_addr, bus_data},
                         {1'b1, 8'h10 + 8'(k), 8'hA0 + 8'(k)});
            end
            tick();
            bus_done = 1'b1;
            bus_rdata = 8'hEE;
            tick();
            bus_done = 1'b0;
            if (i == 3) req = 3'b000;
            total++;
            if ({done, rd_data} !== {order[i], 8'h00}) begin
                bad++;
                $display("FAIL contention_done%0d got=%h exp=%h", i,
                         {done, rd_data}, {order[i], 8'h00});
            end
        end
        drain();
    endtask

    task automatic test_single_read();
        int n;
        bit en_seen;
        req_wr = 3'b000;
        req_addr = {8'h21, 8'h00, 8'h00};
        req_wdata = {8'hFF, 8'h00, 8'h00};
        req = 3'b100;
        tick();
        total++;
        if ({bus_start, bus_en, gnt, bus_wr, bus_addr, bus_data} !==
            {1'b1, 1'b1, 3'b100, 1'b0, 8'h21, 8'h00}) begin
            bad++;
            $display("FAIL read_start got=%h exp=%h",
                     {bus_start, bus_en, gnt, bus_wr, bus_addr, bus_data},
                     {1'b1, 1'b1, 3'b100, 1'b0, 8'h21, 8'h00});
        end
        tick();
        total++;
        if ({bus_start, bus_en} !== 2'b01) begin
            bad++;
            $display("FAIL read_wait got=%b exp=01", {bus_start, bus_en});
        end
        repeat (3) tick();
        bus_done = 1'b1;
        bus_rdata = 8'h45;
        tick();
        bus_done = 1'b0;
        bus_rdata = 8'h00;
        total++;
        if ({done, err, bus_en, rd_data} !== {3'b100, 1'b0, 1'b0, 8'h45}) begin
            bad++;
            $display("FAIL read_done got=%h exp=%h",
                     {done, err, bus_en, rd_data}, {3'b100, 1'b0, 1'b0, 8'h45});
        end
        n = 0;
        en_seen = 1'b0;
        while (bus_start !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (bus_start !== 1'b1 && bus_en !== 1'b0) en_seen = 1'b1;
        end
        total++;
        if (n != GAP + 2 || en_seen) begin
            bad++;
            $display("FAIL read_gap got=%0d en=%0b exp=%0d en=0",
                     n, en_seen, GAP + 2);
        end
        req = 3'b000;
        tick();
        bus_done = 1'b1;
        bus_rdata = 8'h46;
        tick();
        bus_done = 1'b0;
        total++;
        if ({done, rd_data} !== {3'b100, 8'h46}) begin
            bad++;
            $display("FAIL read_again got=%h exp=%h",
                     {done, rd_data}, {3'b100, 8'h46});
        end
        drain();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        req_wr = 3'b001;
        req_addr[0] = 8'h00;
        req_wdata[0] = 8'h10;
        req = 3'b001;
        wait_start(10, ok);
        total++;
        if (!ok || {gnt, bus_wr, bus_addr, bus_data} !==
            {3'b001, 1'b1, 8'h00, 8'h10}) begin
            bad++;
            $display("FAIL timeout_start got=%h exp=%h",
                     {gnt, bus_wr, bus_addr, bus_data}, {3'b001, 1'b1, 8'h00, 8'h10});
        end
        n = 0;
        while (done === 3'b000 && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (n != 4096) begin
            bad++;
            $display("FAIL timeout_len got=%0d exp=4096", n);
        end
        total++;
        if ({done, err, gnt, rd_data} !== {3'b001, 1'b1, 3'b001, 8'h00}) begin
            bad++;
            $display("FAIL timeout_done got=%h exp=%h",
                     {done, err, gnt, rd_data}, {3'b001, 1'b1, 3'b001, 8'h00});
        end
        req = 3'b000;
        tick();
        total++;
        if ({done, err, gnt, bus_en} !== 8'h00) begin
            bad++;
            $display("FAIL timeout_gap got=%b exp=0", {done, err, gnt, bus_en});
        end
        drain();
    endtask

    task automatic test_late_change();
        bit ok;
        bit stable;
        req_wr = 3'b001;
        req_addr[0] = 8'h22;
        req_wdata[0] = 8'h77;
        req = 3'b001;
        wait_start(10, ok);
        tick();
        req_addr[0] = 8'h33;
        req_wdata[0] = 8'h99;
        req_wr = 3'b000;
        stable = ok;
        repeat (3) begin
            tick();
            if ({bus_wr, bus_addr, bus_data} !== {1'b1, 8'h22, 8'h77}) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL late_stable got=%h exp=%h",
                     {bus_wr, bus_addr, bus_data}, {1'b1, 8'h22, 8'h77});
        end
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        req = 3'b000;
        total++;
        if ({done, bus_addr, bus_data} !== {3'b001, 8'h22, 8'h77}) begin
            bad++;
            $display("FAIL late_done got=%h exp=%h",
                     {done, bus_addr, bus_data}, {3'b001, 8'h22, 8'h77});
        end
        drain();
    endtask

    task automatic test_withdraw();
        bit ok;
        req_wr = 3'b000;
        req_addr[1] = 8'h30;
        req = 3'b010;
        wait_start(10, ok);
        total++;
        if (!ok || gnt !== 3'b010) begin
            bad++;
            $display("FAIL withdraw_gnt got=%b exp=010", gnt);
        end
        tick();
        req = 3'b000;
        repeat (2) tick();
        bus_done = 1'b1;
        bus_rdata = 8'h5A;
        tick();
        bus_done = 1'b0;
        total++;
        if ({done, rd_data} !== {3'b010, 8'h5A}) begin
            bad++;
            $display("FAIL withdraw_done got=%h exp=%h",
                     {done, rd_data}, {3'b010, 8'h5A});
        end
        req_wr = 3'b001;
        req = 3'b001;
        wait_start(100, ok);
        total++;
        if (!ok || gnt !== 3'b001) begin
            bad++;
            $display("FAIL withdraw_next got=%b exp=001", gnt);
        end
        tick();
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        req = 3'b000;
        drain();
    endtask

    task automatic test_async_reset();
        bit ok;
        req_wr = 3'b000;
        req = 3'b100;
        wait_start(10, ok);
        total++;
        if (!ok || gnt !== 3'b100) begin
            bad++;
            $display("FAIL areset_pre got=%b exp=100", gnt);
        end
        repeat (2) tick();
        #2;
        Reset = 1'b0;
        #1;
        total++;
        if ({gnt, bus_en, done, bus_start} !== 8'h00) begin
            bad++;
            $display("FAIL areset_now got=%b exp=0", {gnt, bus_en, done, bus_start});
        end
        req = 3'b011;
        req_wr = 3'b011;
        repeat (2) tick();
        Reset = 1'b1;
        wait_start(10, ok);
        total++;
        if (!ok || gnt !== 3'b001) begin
            bad++;
            $display("FAIL areset_first got=%b exp=001", gnt);
        end
        tick();
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        req = 3'b010;
        total++;
        if (done !== 3'b001) begin
            bad++;
            $display("FAIL areset_done got=%b exp=001", done);
        end
        wait_start(100, ok);
        total++;
        if (!ok || gnt !== 3'b010) begin
            bad++;
            $display("FAIL areset_second got=%b exp=010", gnt);
        end
        tick();
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        req = 3'b000;
        drain();
    endtask

    initial begin
        Reset = 1'b0;
        req = '0;
        req_wr = '0;
        req_addr = '0;
        req_wdata = '0;
        bus_done = 1'b0;
        bus_rdata = '0;
        test_reset();
        test_contention();
        test_single_read();
        test_timeout();
        test_late_change();
        test_withdraw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
